// File: rtl/scroll_stepper.sv
// Turns rising edges of the slow scroll clock into offset steps, handed to the renderer via valid/ack.
// Optional SCROLL_BOUNCE_EN: ping-pong scrolling instead of modular wrap.
module scroll_stepper #(
    parameter int OFS_W      = 4,
    parameter int HOLD_TICKS = 3,
    parameter int PEND_MAX   = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             scroll_clk,
    input  logic             run,
    input  logic             dir,
    input  logic             len_load,
    input  logic [OFS_W-1:0] len_in,
    output logic             step_valid,
    input  logic             step_ack,
    output logic [OFS_W-1:0] offset,
    output logic             wrapped,
    output logic             drop_err
);
    localparam int PW = ($clog2(PEND_MAX + 1) < 1) ? 1 : $clog2(PEND_MAX + 1);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [OFS_W-1:0] ONE = OFS_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HOLD} state_t;

    logic             sync1_reg, sync2_reg, prev_reg, tick_reg;
    state_t           state_reg, state_next;
    logic [OFS_W-1:0] len_reg, len_next;
    logic [OFS_W-1:0] offset_reg, offset_next;
    logic [PW-1:0]    pend_reg, pend_next;
    logic [HW-1:0]    hold_reg, hold_next;
    logic             valid_reg, valid_next;
    logic             wrapped_reg, wrapped_next;
    logic             drop_reg, drop_next;
    logic             issue, inc, step_wrap;
    logic [OFS_W-1:0] step_ofs, last_ofs;
`ifdef SCROLL_BOUNCE_EN
    logic             bdir_reg, bdir_next;
`endif

    assign last_ofs = len_reg - ONE;
    assign issue    = (state_reg == RUN) && (pend_reg != '0) && !valid_reg;

    // Offset the next issued step would produce, and whether it hits an end.
    always_comb begin
        step_ofs  = offset_reg;
        step_wrap = 1'b0;
`ifdef SCROLL_BOUNCE_EN
        if (!bdir_reg) begin
            step_ofs  = (offset_reg >= last_ofs) ? last_ofs : offset_reg + ONE;
            step_wrap = (step_ofs == last_ofs);
        end else begin
            step_ofs  = (offset_reg == '0) ? '0 : offset_reg - ONE;
            step_wrap = (step_ofs == '0);
        end
`else
        if (!dir) begin
            step_wrap = (offset_reg >= last_ofs);
            step_ofs  = step_wrap ? '0 : offset_reg + ONE;
        end else begin
            step_wrap = (offset_reg == '0);
            step_ofs  = step_wrap ? last_ofs : offset_reg - ONE;
        end
`endif
    end

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        offset_next  = offset_reg;
        pend_next    = pend_reg;
        hold_next    = hold_reg;
        valid_next   = valid_reg;
        wrapped_next = 1'b0;
        drop_next    = drop_reg;
        inc          = 1'b0;
`ifdef SCROLL_BOUNCE_EN
        bdir_next    = bdir_reg;
`endif

        if (valid_reg && step_ack)
            valid_next = 1'b0;

        if (state_reg == RUN && tick_reg) begin
            if (pend_reg < PW'(PEND_MAX))
                inc = 1'b1;
            else
                drop_next = 1'b1;
        end

        if (issue) begin
            offset_next  = step_ofs;
            valid_next   = 1'b1;
            wrapped_next = step_wrap;
`ifdef SCROLL_BOUNCE_EN
            if (step_wrap)
                bdir_next = ~bdir_reg;
`endif
        end

        case ({inc, issue})
            2'b10:   pend_next = pend_reg + PW'(1);
            2'b01:   pend_next = pend_reg - PW'(1);
            default: pend_next = pend_reg;
        endcase

        case (state_reg)
            IDLE: begin
`ifdef SCROLL_BOUNCE_EN
                // Direction is only taken from the input while idle.
                bdir_next = dir;
`endif
                if (run)
                    state_next = RUN;
            end
            RUN: begin
                if (!run)
                    state_next = PAUSE;
                else if (HOLD_TICKS > 0 && issue && step_wrap) begin
                    state_next = HOLD;
                    hold_next  = '0;
                end
            end
            PAUSE: begin
                if (run)
                    state_next = RUN;
            end
            HOLD: begin
                if (!run) begin
                    state_next = PAUSE;
                    hold_next  = '0;
                end else if (tick_reg) begin
                    if (hold_reg == HW'(HOLD_TICKS - 1)) begin
                        state_next = RUN;
                        hold_next  = '0;
                    end else begin
                        hold_next = hold_reg + HW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A length load overrides any tick, ack or issue in the same cycle.
        if (len_load) begin
            len_next     = (len_in == '0) ? ONE : len_in;
            offset_next  = '0;
            pend_next    = '0;
            valid_next   = 1'b0;
            wrapped_next = 1'b0;
            hold_next    = '0;
            state_next   = IDLE;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            prev_reg    <= 1'b0;
            tick_reg    <= 1'b0;
            state_reg   <= IDLE;
            len_reg     <= ONE;
            offset_reg  <= '0;
            pend_reg    <= '0;
            hold_reg    <= '0;
            valid_reg   <= 1'b0;
            wrapped_reg <= 1'b0;
            drop_reg    <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
            bdir_reg    <= 1'b0;
`endif
        end else begin
            sync1_reg   <= scroll_clk;
            sync2_reg   <= sync1_reg;
            prev_reg    <= sync2_reg;
            tick_reg    <= sync2_reg & ~prev_reg;
            state_reg   <= state_next;
            len_reg     <= len_next;
            offset_reg  <= offset_next;
            pend_reg    <= pend_next;
            hold_reg    <= hold_next;
            valid_reg   <= valid_next;
            wrapped_reg <= wrapped_next;
            drop_reg    <= drop_next;
`ifdef SCROLL_BOUNCE_EN
            bdir_reg    <= bdir_next;
`endif
        end
    end

    assign step_valid = valid_reg;
    assign offset     = offset_reg;
    assign wrapped    = wrapped_reg;
    assign drop_err   = drop_reg;
endmodule

// File: tb/tb_scroll_stepper.sv
// Directed bench for scroll_stepper (default build): expected steps are queued at tick time and
// popped when the DUT presents an offset.
module tb_scroll_stepper;
    logic       clock = 1'b0;
    logic       rst_n;
    logic       scroll_clk;
    logic       run;
    logic       dir;
    logic       len_load;
    logic [3:0] len_in;
    logic       step_valid;
    logic       step_ack;
    logic [3:0] offset;
    logic       wrapped;
    logic       drop_err;

    typedef struct packed {
        logic [3:0] ofs;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   wrap_cnt = 0;
    int   wrap_last = 0;

    scroll_stepper dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .scroll_clk (scroll_clk),
        .run        (run),
        .dir        (dir),
        .len_load   (len_load),
        .len_in     (len_in),
        .step_valid (step_valid),
        .step_ack   (step_ack),
        .offset     (offset),
        .wrapped    (wrapped),
        .drop_err   (drop_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (wrapped === 1'b1) wrap_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        scroll_clk = 1'b1;
        repeat (4) @(negedge clock);
        scroll_clk = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic tick_exp(input logic [3:0] o, input logic w);
        exp_t e;
        e.ofs  = o;
        e.wrap = w;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic load(input logic [3:0] l);
        @(negedge clock);
        len_in   = l;
        len_load = 1'b1;
        @(negedge clock);
        len_load = 1'b0;
        repeat (2) @(negedge clock);
        wrap_last = wrap_cnt;
    endtask

    // Wait (bounded) for a presented step, compare with the queue head, optionally ack it.
    task automatic get_step(input bit do_ack, input string tag);
        exp_t e;
        int   n = 0;
        while (step_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        #1;
        chk({tag, "_valid"}, step_valid, 1);
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_offset"}, offset, e.ofs);
            chk({tag, "_wrapped"}, wrap_cnt - wrap_last, e.wrap);
        end
        wrap_last = wrap_cnt;
        if (do_ack) begin
            @(negedge clock);
            step_ack = 1'b1;
            @(negedge clock);
            step_ack = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; scroll_clk = 1'b0; run = 1'b0; dir = 1'b0;
        len_load = 1'b0; len_in = 4'd0; step_ack = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_offset", offset, 0);
        chk("rst_valid", step_valid, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_drop", drop_err, 0);
        rst_n = 1'b1;
        @(negedge clock);

        // Forward scroll through a wrap, dwell, then resume.
        run = 1'b1;
        load(4'd5);
        tick_exp(4'd1, 1'b0); get_step(1, "fwd1");
        tick_exp(4'd2, 1'b0); get_step(1, "fwd2");
        tick_exp(4'd3, 1'b0); get_step(1, "fwd3");
        tick_exp(4'd4, 1'b0); get_step(1, "fwd4");
        tick_exp(4'd0, 1'b1); get_step(1, "fwd_wrap");
        repeat (3) tick();
        chk("hold_valid", step_valid, 0);
        chk("hold_offset", offset, 0);
        tick_exp(4'd1, 1'b0); get_step(1, "after_hold");

        // Decrement from 0 wraps to len-1.
        dir = 1'b1;
        load(4'd5);
        tick_exp(4'd4, 1'b1); get_step(1, "dec_wrap");
        dir = 1'b0;

        // Backpressure: three queued, fifth edge dropped.
        load(4'd5);
        tick_exp(4'd1, 1'b0);
        tick_exp(4'd2, 1'b0);
        tick_exp(4'd3, 1'b0);
        tick_exp(4'd4, 1'b0);
        chk("bp_no_drop", drop_err, 0);
        tick();
        chk("bp_drop", drop_err, 1);
        chk("bp_hold_offset", offset, 1);
        get_step(1, "bp1");
        get_step(1, "bp2");
        get_step(1, "bp3");
        get_step(1, "bp4");
        repeat (12) @(negedge clock);
        chk("bp_drained", step_valid, 0);

        // Pause freezes the offset and ignores ticks.
        load(4'd5);
        tick_exp(4'd1, 1'b0); get_step(1, "pz1");
        tick_exp(4'd2, 1'b0); get_step(1, "pz2");
        run = 1'b0;
        repeat (4) tick();
        chk("pause_offset", offset, 2);
        chk("pause_valid", step_valid, 0);
        run = 1'b1;
        tick_exp(4'd3, 1'b0); get_step(0, "resume");

        // Length load coincident with a tick and an ack wins.
        scroll_clk = 1'b1;
        repeat (3) @(negedge clock);
        len_in   = 4'd5;
        len_load = 1'b1;
        step_ack = 1'b1;
        @(negedge clock);
        len_load = 1'b0;
        step_ack = 1'b0;
        chk("coll_offset", offset, 0);
        chk("coll_valid", step_valid, 0);
        scroll_clk = 1'b0;
        repeat (12) @(negedge clock);
        chk("coll_no_step", step_valid, 0);
        wrap_last = wrap_cnt;

        // Zero length behaves as one: every step wraps at 0.
        load(4'd0);
        tick_exp(4'd0, 1'b1); get_step(1, "len1");
        chk("drop_sticky", drop_err, 1);

        // Asynchronous reset in the middle of a handshake.
        load(4'd5);
        tick_exp(4'd1, 1'b0); get_step(0, "pre_rst");
        @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", step_valid, 0);
        chk("arst_offset", offset, 0);
        chk("arst_drop", drop_err, 0);
        chk("arst_wrapped", wrapped, 0);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
